// File: rtl/code_lock.sv
// Keypad door lock: edge-detected start/done/keys, CODE_LEN-digit compare, timed result LEDs, lockout.
// Define CODE_LOCK_TIMEOUT_EN to fail an entry after TIMEOUT_CYCLES without key activity.
module code_lock #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    NUM_KEYS       = 10,
  parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter int                    LED_ON_PERIOD  = 300,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 1000,
  parameter int                    TIMEOUT_CYCLES = 500
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            done,
  input  logic [NUM_KEYS-1:0]             button,
  output logic [1:0]                      led,
  output logic                            lockout,
  output logic [$clog2(CODE_LEN+2)-1:0]   digit_cnt
);

  localparam int DW   = $clog2(CODE_LEN + 2);
  localparam int TMAX = (LED_ON_PERIOD > LOCKOUT_CYCLES) ? LED_ON_PERIOD : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_TRIES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_SHOW    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          r_led;
  logic                r_lockout;
  logic [DW-1:0]       r_digit_cnt;
  logic                r_mismatch;
  logic [FW-1:0]       r_fail_cnt;
  logic [TW-1:0]       r_timer;
  logic                r_start_s, r_start_q, r_done_s, r_done_q;
  logic [NUM_KEYS-1:0] r_btn_s, r_btn_q;

  logic                w_start_ev, w_done_ev, w_key_ev, w_key_multi, w_key_ok;
  logic [NUM_KEYS-1:0] w_btn_ev;
  logic [3:0]          w_key_idx, w_exp_digit;
  logic                w_timeout, w_submit, w_pass_now;

  // Pulse is high for the cycle after the first high sample of each input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_s <= 1'b0;
      r_start_q <= 1'b0;
      r_done_s  <= 1'b0;
      r_done_q  <= 1'b0;
      r_btn_s   <= '0;
      r_btn_q   <= '0;
    end else begin
      r_start_s <= start;
      r_start_q <= r_start_s;
      r_done_s  <= done;
      r_done_q  <= r_done_s;
      r_btn_s   <= button;
      r_btn_q   <= r_btn_s;
    end
  end

  assign w_start_ev  = r_start_s & ~r_start_q;
  assign w_done_ev   = r_done_s & ~r_done_q;
  assign w_btn_ev    = r_btn_s & ~r_btn_q;
  assign w_key_ev    = |w_btn_ev;
  assign w_key_multi = |(w_btn_ev & (w_btn_ev - NUM_KEYS'(1)));

  always_comb begin
    w_key_idx   = 4'd0;
    w_exp_digit = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (w_btn_ev[i]) w_key_idx = 4'(i);
    for (int i = 0; i < CODE_LEN; i++)
      if (r_digit_cnt == DW'(i)) w_exp_digit = CODE[4*i +: 4];
  end

  assign w_key_ok = ~w_key_multi & (w_key_idx == w_exp_digit);

`ifdef CODE_LOCK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_idle_cnt <= '0;
    else if (r_state != S_ENTRY || w_start_ev || w_key_ev)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + IW'(1);
  end

  assign w_timeout = (r_state == S_ENTRY) && (r_idle_cnt == IW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // A key arriving in the same cycle as the timeout counts as activity, so it wins.
  assign w_submit   = w_done_ev | (w_timeout & ~w_key_ev);
  assign w_pass_now = w_done_ev & ~r_mismatch & (r_digit_cnt == DW'(CODE_LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_led       <= 2'b00;
      r_lockout   <= 1'b0;
      r_digit_cnt <= '0;
      r_mismatch  <= 1'b0;
      r_fail_cnt  <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ev) begin
            r_state     <= S_ENTRY;
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
          end
        end
        S_ENTRY: begin
          if (w_start_ev) begin
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
          end else if (w_submit) begin
            if (w_pass_now) begin
              r_state    <= S_SHOW;
              r_led      <= 2'b10;
              r_timer    <= TW'(LED_ON_PERIOD - 1);
              r_fail_cnt <= '0;
            end else if (r_fail_cnt >= FW'(MAX_TRIES - 1)) begin
              r_state    <= S_LOCKOUT;
              r_led      <= 2'b01;
              r_lockout  <= 1'b1;
              r_timer    <= TW'(LOCKOUT_CYCLES - 1);
              r_fail_cnt <= FW'(MAX_TRIES);
            end else begin
              r_state    <= S_SHOW;
              r_led      <= 2'b01;
              r_timer    <= TW'(LED_ON_PERIOD - 1);
              r_fail_cnt <= r_fail_cnt + FW'(1);
            end
          end else if (w_key_ev) begin
            if (r_digit_cnt < DW'(CODE_LEN)) begin
              if (!w_key_ok) r_mismatch <= 1'b1;
              r_digit_cnt <= r_digit_cnt + DW'(1);
            end else begin
              r_mismatch  <= 1'b1;
              r_digit_cnt <= DW'(CODE_LEN + 1);
            end
          end
        end
        S_SHOW: begin
          if (w_start_ev) begin
            r_state     <= S_ENTRY;
            r_led       <= 2'b00;
            r_digit_cnt <= '0;
            r_mismatch  <= 1'b0;
          end else if (r_timer == '0) begin
            r_state <= S_IDLE;
            r_led   <= 2'b00;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          if (r_timer == '0) begin
            r_state    <= S_IDLE;
            r_led      <= 2'b00;
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
      endcase
    end
  end

  assign led       = r_led;
  assign lockout   = r_lockout;
  assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_code_lock.sv
// Directed bench for code_lock with default parameters (code 4,3,2,1; 300/3/1000 timing).
module tb_code_lock;

  localparam int P = 300;
  localparam int L = 1000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       done;
  logic [9:0] button;
  logic [1:0] led;
  logic       lockout;
  logic [2:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  code_lock dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .button    (button),
    .led       (led),
    .lockout   (lockout),
    .digit_cnt (digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    start = 1'b1; tick(1); start = 1'b0; tick(1);
  endtask

  task automatic press_done();
    done = 1'b1; tick(1); done = 1'b0; tick(1);
  endtask

  task automatic press_key(input int k);
    button = 10'(1 << k); tick(1); button = '0; tick(1);
  endtask

  task automatic enter_correct();
    press_key(4); press_key(3); press_key(2); press_key(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; done = 1'b0; button = '0;
    tick(3);
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL reset_led: got %b expected 00", led); end
    checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b expected 0", lockout); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_correct_code();
    press_start();
    enter_correct();
    checks++; if (digit_cnt !== 3'd4) begin errors++; $display("FAIL correct_digit_cnt: got %0d expected 4", digit_cnt); end
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL entry_led: got %b expected 00", led); end
    press_done();
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL correct_led_first: got %b expected 10", led); end
    tick(P - 1);
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL correct_led_last: got %b expected 10", led); end
    tick(1);
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL correct_led_off: got %b expected 00", led); end
  endtask

  task automatic test_wrong_digit();
    press_start();
    press_key(4); press_key(3); press_key(9); press_key(1);
    press_done();
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL wrong_digit_led: got %b expected 01", led); end
    tick(P);
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL wrong_digit_off: got %b expected 00", led); end
  endtask

  task automatic test_short_long();
    press_start();
    press_key(4); press_key(3); press_key(2);
    press_done();
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL short_led: got %b expected 01", led); end
    checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL short_lockout: got %b expected 0", lockout); end
    press_start();
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL show_abort_led: got %b expected 00", led); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL show_abort_cnt: got %0d expected 0", digit_cnt); end
    enter_correct();
    press_done();
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL clear_pass_led: got %b expected 10", led); end
    press_start();
    enter_correct();
    press_key(4);
    checks++; if (digit_cnt !== 3'd5) begin errors++; $display("FAIL long_cnt5: got %0d expected 5", digit_cnt); end
    press_key(3);
    checks++; if (digit_cnt !== 3'd5) begin errors++; $display("FAIL long_saturate: got %0d expected 5", digit_cnt); end
    press_done();
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL long_led: got %b expected 01", led); end
    press_start();
  endtask

  task automatic test_priority();
    button = 10'(1 << 4);
    tick(50);
    button = '0;
    tick(1);
    checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL held_key_cnt: got %0d expected 1", digit_cnt); end
    press_key(3); press_key(2); press_key(1);
    press_done();
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL held_key_led: got %b expected 10", led); end
    press_start();
    button = 10'b00_0001_1000; tick(1); button = '0; tick(1);
    press_key(3); press_key(2); press_key(1);
    checks++; if (digit_cnt !== 3'd4) begin errors++; $display("FAIL multi_key_cnt: got %0d expected 4", digit_cnt); end
    press_done();
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL multi_key_led: got %b expected 01", led); end
    press_start();
    press_key(4); press_key(3);
    start = 1'b1; done = 1'b1; tick(1); start = 1'b0; done = 1'b0; tick(1);
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL start_done_cnt: got %0d expected 0", digit_cnt); end
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL start_done_led: got %b expected 00", led); end
    press_key(4); press_key(3); press_key(2);
    button = 10'(1 << 1); done = 1'b1; tick(1); button = '0; done = 1'b0; tick(1);
    checks++; if (digit_cnt !== 3'd3) begin errors++; $display("FAIL done_key_cnt: got %0d expected 3", digit_cnt); end
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL done_key_led: got %b expected 01", led); end
    checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL done_key_lockout: got %b expected 0", lockout); end
    press_start();
    enter_correct();
    press_done();
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL prio_final_pass: got %b expected 10", led); end
    tick(P);
  endtask

  task automatic test_lockout();
    press_start(); press_key(9); press_done();
    checks++; if (led !== 2'b01 || lockout !== 1'b0) begin errors++; $display("FAIL lock_fail1: got led=%b lockout=%b expected led=01 lockout=0", led, lockout); end
    press_start(); press_key(9); press_done();
    checks++; if (led !== 2'b01 || lockout !== 1'b0) begin errors++; $display("FAIL lock_fail2: got led=%b lockout=%b expected led=01 lockout=0", led, lockout); end
    press_start(); press_key(9); press_done();
    checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lock_enter: got %b expected 1", lockout); end
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL lock_led: got %b expected 01", led); end
    press_start();
    press_key(4);
    checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL lock_ignore_cnt: got %0d expected 1", digit_cnt); end
    checks++; if (lockout !== 1'b1 || led !== 2'b01) begin errors++; $display("FAIL lock_ignore_start: got led=%b lockout=%b expected led=01 lockout=1", led, lockout); end
    tick(L - 1 - 4);
    checks++; if (lockout !== 1'b1 || led !== 2'b01) begin errors++; $display("FAIL lock_last_cycle: got led=%b lockout=%b expected led=01 lockout=1", led, lockout); end
    tick(1);
    checks++; if (lockout !== 1'b0 || led !== 2'b00) begin errors++; $display("FAIL lock_exit: got led=%b lockout=%b expected led=00 lockout=0", led, lockout); end
    press_start();
    enter_correct();
    press_done();
    checks++; if (led !== 2'b10) begin errors++; $display("FAIL lock_after_pass: got %b expected 10", led); end
  endtask

  task automatic test_reset_mid();
    press_start(); press_key(9); press_done();
    press_start(); press_key(9); press_done();
    press_start(); press_key(4);
    checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d expected 1", digit_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (digit_cnt !== 3'd0 || led !== 2'b00 || lockout !== 1'b0) begin errors++; $display("FAIL async_reset: got cnt=%0d led=%b lockout=%b expected cnt=0 led=00 lockout=0", digit_cnt, led, lockout); end
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    press_start(); press_key(9); press_done();
    checks++; if (lockout !== 1'b0 || led !== 2'b01) begin errors++; $display("FAIL reset_clears_fails: got led=%b lockout=%b expected led=01 lockout=0", led, lockout); end
    tick(P);
  endtask

`ifdef CODE_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    press_start();
    press_key(4);
    tick(490);
    checks++; if (led !== 2'b00) begin errors++; $display("FAIL timeout_early: got %b expected 00", led); end
    tick(20);
    checks++; if (led !== 2'b01) begin errors++; $display("FAIL timeout_led: got %b expected 01", led); end
    tick(P);
  endtask
`endif

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_digit();
    test_short_long();
    test_priority();
    test_lockout();
    test_reset_mid();
`ifdef CODE_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
